// File: rtl/cakegame_uc_if.sv
// Control/status bundle between the cake-game control unit and its datapath.
// The control unit drives every datapath control line; the datapath returns its status flags.
interface cakegame_uc_if;
  logic       end_mem_counter;
  logic       correct_play;
  logic       has_play;
  logic       end_show;
  logic       timeout;
  logic [1:0] out_sel;
  logic       clear_reg;
  logic       enable_reg;
  logic       clear_mem_counter;
  logic       enable_mem_counter;
  logic       clear_show_counter;
  logic       enable_show_counter;
  logic       enable_timeout_counter;
  logic       clear_points_counter;
  logic       enable_points_counter;

  modport master (
    input  end_mem_counter, correct_play, has_play, end_show, timeout,
    output out_sel, clear_reg, enable_reg, clear_mem_counter, enable_mem_counter,
           clear_show_counter, enable_show_counter, enable_timeout_counter,
           clear_points_counter, enable_points_counter
  );

  modport slave (
    output end_mem_counter, correct_play, has_play, end_show, timeout,
    input  out_sel, clear_reg, enable_reg, clear_mem_counter, enable_mem_counter,
           clear_show_counter, enable_show_counter, enable_timeout_counter,
           clear_points_counter, enable_points_counter
  );
endinterface

// File: rtl/cakegame_uc.sv
// Cake-game control unit: Moore FSM that clears the datapath, shows each ROM entry,
// waits for and scores the player's press, and ends the game as won or lost.
module cakegame_uc (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 srst_i,
  input  logic                 start_i,
  cakegame_uc_if.master        dp,
  output logic                 finished_o,
  output logic                 won_o,
  output logic [3:0]           db_state_o
);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_INIT     = 4'd1,
    ST_SHOW     = 4'd2,
    ST_WAIT     = 4'd3,
    ST_REGISTER = 4'd4,
    ST_COMPARE  = 4'd5,
    ST_SCORE    = 4'd6,
    ST_NEXT     = 4'd7,
    ST_LOST     = 4'd12,
    ST_WON      = 4'd13
  } state_e;

  typedef struct packed {
    logic [1:0] out_sel;
    logic       clear_reg;
    logic       enable_reg;
    logic       clear_mem;
    logic       clear_show;
    logic       enable_show;
    logic       enable_timeout;
    logic       clear_points;
    logic       enable_points;
    logic       finished;
    logic       won;
  } ctrl_t;

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;

  // Next-state selection; a soft reset returns to idle on the next edge
  always_comb begin
    state_d = state_q;
    if (srst_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     if (start_i) state_d = ST_INIT; else state_d = ST_IDLE;
        ST_INIT:     state_d = ST_SHOW;
        ST_SHOW:     if (dp.end_show) state_d = ST_WAIT; else state_d = ST_SHOW;
        ST_WAIT: begin
          if (dp.has_play)     state_d = ST_REGISTER;
          else if (dp.timeout) state_d = ST_LOST;
          else                 state_d = ST_WAIT;
        end
        ST_REGISTER: state_d = ST_COMPARE;
        ST_COMPARE:  if (dp.correct_play) state_d = ST_SCORE; else state_d = ST_NEXT;
        ST_SCORE:    state_d = ST_NEXT;
        ST_NEXT:     if (dp.end_mem_counter) state_d = ST_WON; else state_d = ST_SHOW;
        ST_LOST:     if (start_i) state_d = ST_INIT; else state_d = ST_LOST;
        ST_WON:      if (start_i) state_d = ST_INIT; else state_d = ST_WON;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // Decode the state being entered so the Moore outputs register together with it
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      ST_INIT: begin
        ctrl_d.clear_reg    = 1'b1;
        ctrl_d.clear_mem    = 1'b1;
        ctrl_d.clear_show   = 1'b1;
        ctrl_d.clear_points = 1'b1;
      end
      ST_SHOW: begin
        ctrl_d.enable_show = 1'b1;
        ctrl_d.out_sel     = 2'd1;
      end
      ST_WAIT: begin
        ctrl_d.enable_timeout = 1'b1;
        ctrl_d.out_sel        = 2'd2;
      end
      ST_REGISTER: begin
        ctrl_d.enable_reg = 1'b1;
        ctrl_d.out_sel    = 2'd2;
      end
      ST_COMPARE:  ctrl_d.out_sel       = 2'd2;
      ST_SCORE:    ctrl_d.enable_points = 1'b1;
      ST_NEXT:     ctrl_d.clear_show    = 1'b1;
      ST_LOST:     ctrl_d.finished      = 1'b1;
      ST_WON: begin
        ctrl_d.finished = 1'b1;
        ctrl_d.won      = 1'b1;
      end
      default:     ctrl_d = '0;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Address never wraps: at the last entry the game ends instead of incrementing
  assign dp.enable_mem_counter     = (state_q == ST_NEXT) && !dp.end_mem_counter;
  assign dp.out_sel                = ctrl_q.out_sel;
  assign dp.clear_reg              = ctrl_q.clear_reg;
  assign dp.enable_reg             = ctrl_q.enable_reg;
  assign dp.clear_mem_counter      = ctrl_q.clear_mem;
  assign dp.clear_show_counter     = ctrl_q.clear_show;
  assign dp.enable_show_counter    = ctrl_q.enable_show;
  assign dp.enable_timeout_counter = ctrl_q.enable_timeout;
  assign dp.clear_points_counter   = ctrl_q.clear_points;
  assign dp.enable_points_counter  = ctrl_q.enable_points;
  assign finished_o                = ctrl_q.finished;
  assign won_o                     = ctrl_q.won;
  assign db_state_o                = state_q;

endmodule

// File: tb/tb_cakegame_uc.sv
// Self-checking bench for cakegame_uc: randomized games against a game-level reference
// model, with a scoreboard monitor that checks each game's outcome when it finishes.
module tb_cakegame_uc;
  logic       clk = 1'b0;
  logic       rst, srst, start;
  logic       finished, won;
  logic [3:0] db_state;

  cakegame_uc_if dp ();

  always #5 clk = ~clk;

  cakegame_uc dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .srst_i     (srst),
    .start_i    (start),
    .dp         (dp),
    .finished_o (finished),
    .won_o      (won),
    .db_state_o (db_state)
  );

  // Minimal datapath stand-in: address and score counters driven by the DUT controls
  logic [4:0] addr_q;
  logic [5:0] points_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= 5'd0;
      points_q <= 6'd0;
    end else begin
      if (dp.clear_mem_counter)         addr_q <= 5'd0;
      else if (dp.enable_mem_counter)   addr_q <= addr_q + 5'd1;
      if (dp.clear_points_counter)      points_q <= 6'd0;
      else if (dp.enable_points_counter) points_q <= points_q + 6'd1;
    end
  end
  assign dp.end_mem_counter = (addr_q == 5'd15);

  typedef struct {
    bit won;
    int points;
    int addr;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;
  bit [1:0] plan_act[16];   // 0 = correct press, 1 = wrong press, 2 = timeout
  bit       plan_both[16];  // timeout raised in the same cycle as the press

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] all_outs();
    return {dp.out_sel, dp.clear_reg, dp.enable_reg, dp.clear_mem_counter,
            dp.enable_mem_counter, dp.clear_show_counter, dp.enable_show_counter,
            dp.enable_timeout_counter, dp.clear_points_counter, dp.enable_points_counter,
            finished, won, db_state};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every newly finished game is compared with the oldest prediction
  initial begin
    bit   fin_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (finished === 1'b1 && !fin_prev) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("game_won", {31'd0, won}, {31'd0, e.won});
          chk("game_points", {26'd0, points_q}, e.points);
          chk("game_addr", {27'd0, addr_q}, e.addr);
          chk("game_state", {28'd0, db_state}, e.won ? 32'd13 : 32'd12);
          chk("game_out_sel", {30'd0, dp.out_sel}, 32'd0);
        end
      end
      fin_prev = (finished === 1'b1);
    end
  end

  task automatic start_game();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("init_clears", {28'd0, dp.clear_reg, dp.clear_mem_counter, dp.clear_show_counter,
                        dp.clear_points_counter}, 32'hF);
    step();
    chk("show_clears", {28'd0, dp.clear_reg, dp.clear_mem_counter, dp.clear_show_counter,
                        dp.clear_points_counter}, 32'h0);
    chk("first_show", {30'd0, dp.out_sel}, 32'd1);
  endtask

  task automatic play_game(input bit fixed_wait);
    exp_t e;
    int   lat, d, w;
    logic [3:0] prev;
    e.won = 1'b1; e.points = 0; e.addr = 0;
    for (int i = 0; i < 16; i++) begin
      if (plan_act[i] == 2'd2) begin
        e.won = 1'b0;
        break;
      end
      if (plan_act[i] == 2'd0) e.points++;
      if (i < 15) e.addr++;
    end
    sb.push_back(e);
    start_game();
    for (int i = 0; i < 16; i++) begin
      d = $urandom_range(0, 3);
      repeat (d) step();
      dp.end_show = 1'b1;
      step();
      dp.end_show = 1'b0;
      chk("wait_state", {28'd0, db_state}, 32'd3);
      w = fixed_wait ? 1 : $urandom_range(0, 3);
      repeat (w) step();
      if (plan_act[i] == 2'd2) begin
        dp.timeout = 1'b1;
        step();
        dp.timeout = 1'b0;
        return;
      end
      dp.has_play     = 1'b1;
      dp.correct_play = (plan_act[i] == 2'd0);
      dp.timeout      = plan_both[i];
      step();
      dp.has_play = 1'b0;
      dp.timeout  = 1'b0;
      if (plan_both[i]) chk("press_beats_timeout", {28'd0, db_state}, 32'd4);
      lat = 1;
      for (int k = 0; k < 10 && !(dp.out_sel == 2'd1 || finished === 1'b1); k++) begin
        prev = db_state;
        step();
        lat++;
        if (prev == 4'd5 && plan_act[i] == 2'd1) chk("wrong_skips_score", {28'd0, db_state}, 32'd7);
      end
      chk("entry_latency", lat, (plan_act[i] == 2'd0) ? 32'd5 : 32'd4);
      if (finished === 1'b1 && i < 15) begin
        chk("early_finish", i, 32'd15);
        return;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; srst = 1'b0; start = 1'b0;
    dp.correct_play = 1'b0; dp.has_play = 1'b0; dp.end_show = 1'b0; dp.timeout = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("reset_outputs", {15'd0, all_outs()}, 32'd0);

    // All 16 entries correct, press two cycles after each end of show
    for (int i = 0; i < 16; i++) begin plan_act[i] = 2'd0; plan_both[i] = 1'b0; end
    play_game(1'b1);
    chk("won_points_16", {26'd0, points_q}, 32'd16);

    // Wrong press, simultaneous press/timeout, then a timeout loss
    for (int i = 0; i < 16; i++) begin plan_act[i] = 2'd0; plan_both[i] = 1'b0; end
    plan_act[0] = 2'd1; plan_both[1] = 1'b1; plan_act[2] = 2'd1; plan_act[3] = 2'd2;
    play_game(1'b0);
    chk("lost_not_won", {31'd0, won}, 32'd0);

    // Randomized games: a full game with random misses, then games that may time out
    for (int g = 0; g < 6; g++) begin
      for (int i = 0; i < 16; i++) begin
        if (g > 0 && $urandom_range(0, 19) == 0) plan_act[i] = 2'd2;
        else plan_act[i] = ($urandom_range(0, 3) == 0) ? 2'd1 : 2'd0;
        plan_both[i] = ($urandom_range(0, 7) == 0);
      end
      play_game(1'b0);
    end
    step();

    // Asynchronous reset in wait_play clears everything before the next edge
    start_game();
    dp.end_show = 1'b1;
    step();
    dp.end_show = 1'b0;
    chk("pre_reset_wait", {28'd0, db_state}, 32'd3);
    #3 rst = 1'b1;
    #1 chk("async_reset_outputs", {15'd0, all_outs()}, 32'd0);
    step();
    rst = 1'b0;
    step();

    // Soft reset from show returns to idle on the next edge
    start_game();
    srst = 1'b1;
    step();
    srst = 1'b0;
    chk("soft_reset_outputs", {15'd0, all_outs()}, 32'd0);

    repeat (3) step();
    chk("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
